// File: rtl/alu_nibble_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared state encoding and ALU mode constants for the
//            nibble-serial sequencer around the alu4 slice.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] mode_t;

  // Sequencer states
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // alu4 mode encoding carried on M / AluM
  localparam mode_t M_NAND = 2'd0;
  localparam mode_t M_NOR  = 2'd1;
  localparam mode_t M_ADD  = 2'd2;
  localparam mode_t M_PASS = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_seq_if
// Purpose  : Request/result bundle between a requester (master) and the
//            nibble-serial sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  // Request side
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             Ai;
  logic             Bi;
  logic             Cin;
  logic [1:0]       M;

  // Result side
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             Zero;
  logic             Overflow;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, A, B, C, Ai, Bi, Cin, M,
    input  Result, Carry, Zero, Overflow, Busy, Done
  );

  modport slave (
    input  Start, A, B, C, Ai, Bi, Cin, M,
    output Result, Carry, Zero, Overflow, Busy, Done
  );

endinterface
`default_nettype wire

// File: rtl/alu_nibble_seq_nib_shreg.sv
`default_nettype none
// ============================================================================
// Module   : nib_shreg
// Purpose  : WIDTH-bit loadable register that shifts right by one nibble,
//            inserting a new nibble at the top on every shift.
// Revision : 1.0 - initial release
// ============================================================================
module nib_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [3:0]       nib_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Load has priority over shift; the two are never requested together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {nib_i, data_q[WIDTH-1:4]};
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_seq
// Purpose  : Nibble-serial sequencer for one external alu4 slice. Latches a
//            WIDTH-bit operation, feeds the slice LSB nibble first with the
//            carry chained through a register, and collects the result with
//            Carry/Zero(/Overflow) flags and a one-cycle Done pulse.
// Options  : ALU_NIBBLE_SEQ_OVF_EN - adds signed-overflow detection for ADD.
// Revision : 1.0 - initial release
// ============================================================================
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  alu_nibble_seq_if.slave bus,
  output logic [3:0]     AluA,
  output logic [3:0]     AluB,
  output logic [3:0]     AluC,
  output logic           AluAi,
  output logic           AluBi,
  output logic           AluKin,
  output logic [1:0]     AluM,
  input  logic [3:0]     AluOut,
  input  logic           AluKout
);

  localparam int            WIDTH  = 4 * NIBBLES;
  localparam int            NW     = $clog2(NIBBLES);
  localparam logic [NW-1:0] N_LAST = NW'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic             ai_q, bi_q, k_q, z_q;
  mode_t            m_q;
  logic [NW-1:0]    n_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, r_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q;

  logic accept;
  logic running;
  logic last;

  assign accept  = bus.Start && ((state_q == IDLE) || (state_q == DONE));
  assign running = (state_q == RUN);
  assign last    = running && (n_q == N_LAST);

  // Operand and result shift registers; operands shift out toward the slice,
  // the working result fills from the top with each slice output
  nib_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk_i(Clk), .rst_i(Reset), .load_i(accept), .shift_i(running),
    .load_val_i(bus.A), .nib_i(4'd0), .q_o(a_q)
  );
  nib_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk_i(Clk), .rst_i(Reset), .load_i(accept), .shift_i(running),
    .load_val_i(bus.B), .nib_i(4'd0), .q_o(b_q)
  );
  nib_shreg #(.WIDTH(WIDTH)) u_sh_c (
    .clk_i(Clk), .rst_i(Reset), .load_i(accept), .shift_i(running),
    .load_val_i(bus.C), .nib_i(4'd0), .q_o(c_q)
  );
  nib_shreg #(.WIDTH(WIDTH)) u_sh_r (
    .clk_i(Clk), .rst_i(Reset), .load_i(accept), .shift_i(running),
    .load_val_i('0), .nib_i(AluOut), .q_o(r_q)
  );

  // Upper operand nibbles are consumed only inside the shift registers, and
  // the lowest working-result nibble is shifted out on the final edge
  logic unused_bits;
  assign unused_bits = ^{a_q[WIDTH-1:4], b_q[WIDTH-1:4], c_q[WIDTH-1:4], r_q[3:0]};

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    state_d = bus.Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slice drive comes straight from the latched registers
  always_comb begin
    AluA     = a_q[3:0];
    AluB     = b_q[3:0];
    AluC     = c_q[3:0];
    AluAi    = ai_q;
    AluBi    = bi_q;
    AluKin   = k_q;
    AluM     = m_q;
    bus.Busy = (state_q == RUN);
    bus.Done = (state_q == DONE);
  end

  // Control latches, carry chain, nibble counter and zero accumulator
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ai_q <= 1'b0;
      bi_q <= 1'b0;
      m_q  <= M_NAND;
      k_q  <= 1'b0;
      z_q  <= 1'b0;
      n_q  <= '0;
    end else if (accept) begin
      ai_q <= bus.Ai;
      bi_q <= bus.Bi;
      m_q  <= bus.M;
      k_q  <= bus.Cin;
      z_q  <= 1'b1;
      n_q  <= '0;
    end else if (running) begin
      k_q  <= AluKout;
      z_q  <= z_q & (AluOut == 4'd0);
      n_q  <= n_q + 1'b1;
    end
  end

  // Visible result and flags update only when an operation completes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else if (last) begin
      result_q <= {AluOut, r_q[WIDTH-1:4]};
      carry_q  <= (m_q == M_ADD) ? AluKout : 1'b0;
      zero_q   <= z_q & (AluOut == 4'd0);
    end
  end

  assign bus.Result = result_q;
  assign bus.Carry  = carry_q;
  assign bus.Zero   = zero_q;

`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic ovf_q;

  // Carry into the sign bit (a^b^sum) XOR carry out of it, on the top nibble
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (m_q == M_ADD) ?
               ((AluA[3] ^ AluAi) ^ (AluB[3] ^ AluBi) ^ AluOut[3] ^ AluKout) : 1'b0;
    end
  end

  assign bus.Overflow = ovf_q;
`else
  assign bus.Overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Nibble-serial sequencer wrapped around one 4-bit ALU slice (alu4).
- Upstream role: latches a WIDTH-bit operation and feeds the slice one nibble per clock, LSB nibble first, with Ai/Bi/M held constant and Kin chained.
- Downstream role: collects slice Out/Kout into a result register and produces Carry/Zero flags plus a Done pulse.
- Gives the TTL datapath 8/16-bit arithmetic without extra slices.

Parameters:
- NIBBLES, 4, operand width in nibbles; WIDTH = 4*NIBBLES; legal range 2..8.

Ports:
- Clk, input, 1, system clock; all state updates on its rising edge.
- Reset, input, 1, synchronous, active-high reset.
- Start, input, 1, request; sampled only when accepting (see Behaviour).
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B.
- C, input, WIDTH, pass-through data for M=3.
- Ai, input, 1, invert A.
- Bi, input, 1, invert B.
- Cin, input, 1, carry-in for nibble 0.
- M, input, 2, mode: 0 NAND, 1 NOR, 2 ADD, 3 PASS C.
- AluA, output, 4, current A nibble to the slice.
- AluB, output, 4, current B nibble to the slice.
- AluC, output, 4, current C nibble to the slice.
- AluAi, output, 1, latched Ai.
- AluBi, output, 1, latched Bi.
- AluKin, output, 1, slice carry-in.
- AluM, output, 2, latched M.
- AluOut, input, 4, slice result.
- AluKout, input, 1, slice carry-out.
- Result, output, WIDTH, final result.
- Carry, output, 1, final carry; meaningful for ADD only.
- Zero, output, 1, Result == 0.
- Overflow, output, 1, signed overflow (see Optional Feature).
- Busy, output, 1, operation in progress.
- Done, output, 1, one-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset takes effect at the next Clk edge regardless of state, including mid-RUN. After reset: state IDLE; Result=0, Carry=0, Zero=0, Overflow=0, Busy=0, Done=0; all Alu* outputs 0; operand registers 0.
- FSM states: IDLE, RUN, DONE.
- Accepting:
  - Start is accepted when state is IDLE or DONE.
  - On acceptance, latch A, B, C, Ai, Bi, M, and set carry register k = Cin. Clear nibble counter n = 0, set zero accumulator z = 1, then go to RUN.
  - Start in RUN is ignored.
- RUN, combinational outputs:
  - AluA/AluB/AluC = bits [3:0] of the operand shift registers.
  - AluKin = k.
  - AluAi/AluBi/AluM = latched values.
  - Busy = 1.
- RUN, each edge:
  - Result shift register shifts right 4 with AluOut inserted at bits [WIDTH-1:WIDTH-4].
  - Operand registers shift right 4.
  - k <= AluKout.
  - z <= z & (AluOut == 0).
  - n <= n+1.
  - When n == NIBBLES-1, go to DONE.
- Entering DONE:
  - Carry <= AluKout if latched M == 2, else 0.
  - Zero <= z & (AluOut == 0).
- DONE: Done = 1, Busy = 0. Go to IDLE next cycle, or directly to RUN if Start is asserted.
- Latency: Start accepted at edge T gives Done high for cycle T+NIBBLES+1.
- Holding: Result, Carry, Zero and Overflow hold until the next operation reaches DONE. During RUN they show the previous values; the shift register is internal and copied to Result on DONE entry.
- IDLE/DONE: Alu* outputs are driven from the latched registers and are don't-care to the consumer.
- Subtraction convention: Bi=1, Cin=1. Carry=1 means no borrow.

Optional Feature:
- Macro: ALU_NIBBLE_SEQ_OVF_EN.
- When defined, on DONE entry with M == 2: Overflow <= (AluA[3]^AluAi) ^ (AluB[3]^AluBi) ^ AluOut[3] ^ AluKout, evaluated on the top nibble. It is 0 for other modes.
- When undefined, Overflow is tied 0 and no related logic exists.

Decomposition:
- Package alu_seq_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: M_NAND=0, M_NOR=1, M_ADD=2, M_PASS=3.
- One sub-module, nib_shreg: a WIDTH-bit loadable right-shift-by-4 register with a nibble insert port. It is instantiated for A, B, C and the result.
- alu4 stays external; the integration bench connects the two.

Test Plan (NIBBLES=4, alu4 connected):
- ADD 0x1234+0x0FCD, Ai=Bi=Cin=0, Start at edge T -> Done at cycle T+5; Result=0x2201, Carry=0, Zero=0.
- ADD 0xFFFF+0x0001, Cin=0 -> Result=0x0000, Carry=1, Zero=1. With ALU_NIBBLE_SEQ_OVF_EN: Overflow=0.
- SUB 0x8000-0x0001 (Bi=1, Cin=1) -> Result=0x7FFF, Carry=1, Overflow=1 with the macro, 0 without. SUB 0x0005-0x0007 -> 0xFFFE, Carry=0.
- NAND A=0xF0F0, B=0xFF00 -> 0x0FFF, Carry=0. Then PASS with C=0xBEEF -> 0xBEEF. Start asserted in the DONE cycle chains the operations with no IDLE gap.
- Start pulsed again during RUN -> ignored; exactly one Done, and the result belongs to the first operands.
- Reset asserted in the 2nd RUN cycle -> next cycle IDLE with all outputs 0. A following ADD 0x0001+0x0001 gives Result=0x0002.
